// File: rtl/soc_system_mode_ctrl_pio.sv
// soc_system_mode_ctrl_pio: Avalon-MM output PIO for WIDTH mode-control lines.
// Adds atomic set/clear, a timed one-shot inversion pulse, and a key-unlock
// write protection (one protected write per unlock, bounded unlock window).
module soc_system_mode_ctrl_pio #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               PULSE_CYCLES  = 50000,
    parameter bit               LOCK_EN       = 1'b1,
    parameter logic [31:0]      UNLOCK_KEY    = 32'h4D4F4445,
    parameter int               UNLOCK_WINDOW = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    localparam int PCW = $clog2(PULSE_CYCLES + 1);
    localparam int WCW = $clog2(UNLOCK_WINDOW + 1);

    typedef enum logic {ST_LOCKED = 1'b0, ST_UNLOCKED = 1'b1} lock_state_t;

    lock_state_t      r_state, w_state_nxt;
    logic [WCW-1:0]   r_win_cnt, w_win_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_pulse_mask;
    logic [PCW-1:0]   r_pulse_cnt;
    logic             r_viol;

    logic             w_wr, w_rd, w_prot_wr, w_key_wr, w_key_ok;
    logic             w_accept, w_viol_set, w_viol_clr;
    logic [WIDTH-1:0] w_wd;
    logic [31:0]      w_rdata;

    assign w_wr       = chipselect & ~write_n;
    assign w_rd       = chipselect & ~read_n;
    assign w_prot_wr  = w_wr & (address <= 3'd3);
    assign w_key_wr   = w_wr & (address == 3'd5);
    assign w_key_ok   = (writedata == UNLOCK_KEY);
    assign w_viol_clr = w_wr & (address == 3'd4) & writedata[2];
    assign w_wd       = writedata[WIDTH-1:0];
    assign irq        = r_viol;

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= LOCK_EN ? ST_LOCKED : ST_UNLOCKED;
            r_win_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_win_cnt <= w_win_nxt;
        end
    end

    // Lock FSM next state: gates protected writes and flags violations
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_cnt;
        w_accept    = 1'b0;
        w_viol_set  = 1'b0;
        if (!LOCK_EN) begin
            w_state_nxt = ST_UNLOCKED;
            w_win_nxt   = '0;
            w_accept    = w_prot_wr;
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    if (w_key_wr && w_key_ok) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_win_nxt   = WCW'(UNLOCK_WINDOW);
                    end else if (w_key_wr || w_prot_wr) begin
                        w_viol_set = 1'b1;
                    end
                end
                ST_UNLOCKED: begin
                    if (w_prot_wr) begin
                        // one protected write per unlock
                        w_accept    = 1'b1;
                        w_state_nxt = ST_LOCKED;
                        w_win_nxt   = '0;
                    end else if (w_key_wr && w_key_ok) begin
                        w_win_nxt = WCW'(UNLOCK_WINDOW);
                    end else if (w_key_wr) begin
                        w_state_nxt = ST_LOCKED;
                        w_win_nxt   = '0;
                        w_viol_set  = 1'b1;
                    end else if (r_win_cnt <= WCW'(1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_win_nxt   = '0;
                    end else begin
                        w_win_nxt = r_win_cnt - WCW'(1);
                    end
                end
                default: w_state_nxt = ST_LOCKED;
            endcase
        end
    end

    // Data register, pulse timer, violation flag and registered out_port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data       <= RESET_VALUE;
            r_pulse_mask <= '0;
            r_pulse_cnt  <= '0;
            r_viol       <= 1'b0;
            out_port     <= RESET_VALUE;
        end else begin
            // timer runs first so a PULSE write on the expiry cycle reloads
            if (r_pulse_cnt != '0) begin
                r_pulse_cnt <= r_pulse_cnt - PCW'(1);
                if (r_pulse_cnt == PCW'(1))
                    r_pulse_mask <= '0;
            end
            if (w_accept) begin
                case (address[1:0])
                    2'd0: r_data <= w_wd;
                    2'd1: r_data <= r_data | w_wd;
                    2'd2: r_data <= r_data & ~w_wd;
                    default: begin
                        r_pulse_mask <= w_wd;
                        r_pulse_cnt  <= (w_wd == '0) ? '0 : PCW'(PULSE_CYCLES);
                    end
                endcase
            end
            // a violation in the same cycle as a clear keeps the flag set
            r_viol   <= w_viol_set | (r_viol & ~w_viol_clr);
            out_port <= r_data ^ r_pulse_mask;
        end
    end

    // Read mux from current (pre-write) register values
    always_comb begin
        w_rdata = '0;
        case (address)
            3'd0: w_rdata[WIDTH-1:0] = r_data;
            3'd4: w_rdata[2:0] = {r_viol, (r_pulse_cnt != '0), (r_state == ST_UNLOCKED)};
            3'd6: w_rdata[WIDTH-1:0] = out_port;
            default: w_rdata = '0;
        endcase
    end

    // Fixed read latency of one; zero on non-read cycles
    always_ff @(posedge clk) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= w_rd ? w_rdata : 32'd0;
    end

endmodule

// File: tb/tb_soc_system_mode_ctrl_pio.sv
// Testbench for soc_system_mode_ctrl_pio: directed bus stimulus pushes
// cycle-stamped expectations into a scoreboard queue; a monitor process
// compares DUT outputs on the falling edge when each stamp comes due.
module tb_soc_system_mode_ctrl_pio;
    localparam logic [31:0] KEY = 32'h4D4F4445;
    localparam int K_RD = 0, K_OUT = 1, K_IRQ = 2, K_RD2 = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0, write_n = 1'b1, read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, readdata2;
    logic [7:0]  out_port, out_port2;
    logic        irq, irq2;

    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    soc_system_mode_ctrl_pio #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CYCLES(10), .LOCK_EN(1'b1),
        .UNLOCK_KEY(KEY), .UNLOCK_WINDOW(256)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(readdata), .out_port(out_port), .irq(irq)
    );

    soc_system_mode_ctrl_pio #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CYCLES(10), .LOCK_EN(1'b0),
        .UNLOCK_KEY(KEY), .UNLOCK_WINDOW(256)
    ) dut_nolock (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(readdata2), .out_port(out_port2), .irq(irq2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every expectation stamped for this cycle
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                logic [31:0] act;
                case (sbq[i].kind)
                    K_RD:    act = readdata;
                    K_OUT:   act = {24'd0, out_port};
                    K_IRQ:   act = {31'd0, irq};
                    default: act = readdata2;
                endcase
                checks++;
                if (act !== sbq[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             sbq[i].name, act, sbq[i].exp, cyc);
                end
                sbq.delete(i);
            end else if (sbq[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared", sbq[i].name, sbq[i].cyc);
                sbq.delete(i);
            end
        end
    end

    task automatic push(input int d, input int k, input string n, input logic [31:0] e);
        exp_t t;
        t.cyc = cyc + d; t.kind = k; t.name = n; t.exp = e;
        sbq.push_back(t);
    endtask

    task automatic tick(input logic rst, input logic cs, input logic wn, input logic rn,
                        input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        reset_n = rst; chipselect = cs; write_n = wn; read_n = rn;
        address = a; writedata = d;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        tick(1'b1, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        tick(1'b1, 1'b1, 1'b1, 1'b0, a, 32'd0);
        push(1, K_RD, n, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd0);
        idle(1);
        push(1, K_OUT, "rst_out", 32'hA5);
        push(1, K_IRQ, "rst_irq", 32'd0);
        push(1, K_RD, "rst_readdata", 32'd0);
        rd(3'd4, 32'h0, "rst_status");
        push(1, K_RD2, "rst_status_nolock", 32'h1);

        // protected write while locked
        wr(3'd0, 32'h3C);
        push(1, K_IRQ, "locked_wr_irq", 32'd1);
        push(2, K_OUT, "locked_wr_out", 32'hA5);
        rd(3'd4, 32'h4, "locked_wr_status");
        // read + write STATUS together: read sees pre-clear value
        tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h4);
        push(1, K_RD, "rw_status_prewrite", 32'h4);
        push(1, K_IRQ, "viol_clear_irq", 32'd0);

        // key then SET; second write without re-key is rejected
        wr(3'd5, KEY);
        rd(3'd4, 32'h1, "unlocked_status");
        wr(3'd1, 32'h03);
        push(2, K_OUT, "set_out", 32'hA7);
        rd(3'd4, 32'h0, "relocked_status");
        wr(3'd2, 32'h80);
        push(1, K_IRQ, "clr_nokey_irq", 32'd1);
        push(2, K_OUT, "clr_nokey_out", 32'hA7);
        rd(3'd0, 32'hA7, "data_read");
        wr(3'd4, 32'h4);
        wr(3'd5, KEY);
        wr(3'd2, 32'h80);
        push(2, K_OUT, "clr_out", 32'h27);
        push(1, K_IRQ, "clr_irq", 32'd0);
        rd(3'd0, 32'h27, "data_after_clr");
        rd(3'd6, 32'h27, "out_reg_read");

        // wrong key while locked, wrong key while unlocked
        wr(3'd5, 32'h12345678);
        push(1, K_IRQ, "badkey_locked_irq", 32'd1);
        wr(3'd4, 32'h4);
        wr(3'd5, KEY);
        wr(3'd5, 32'hDEADBEEF);
        rd(3'd4, 32'h4, "badkey_unlocked_status");
        wr(3'd4, 32'h4);

        // unlock window expired: write 257 cycles after the key edge
        wr(3'd5, KEY);
        idle(256);
        wr(3'd0, 32'h00);
        push(1, K_IRQ, "window_expired_irq", 32'd1);
        push(2, K_OUT, "window_expired_out", 32'h27);
        wr(3'd4, 32'h4);
        // write 255 cycles after the key edge is still inside the window
        wr(3'd5, KEY);
        idle(254);
        wr(3'd0, 32'h55);
        push(1, K_IRQ, "window_ok_irq", 32'd0);
        push(2, K_OUT, "window_ok_out", 32'h55);
        wr(3'd5, KEY);
        wr(3'd0, 32'h27);
        push(2, K_OUT, "restore_out", 32'h27);

        // 10-cycle pulse on bit0
        wr(3'd5, KEY);
        wr(3'd3, 32'h01);
        push(1, K_OUT, "pulse_pre", 32'h27);
        for (int d = 2; d <= 11; d++) push(d, K_OUT, "pulse_active", 32'h26);
        push(12, K_OUT, "pulse_end", 32'h27);
        rd(3'd4, 32'h2, "pulse_busy");
        idle(12);
        rd(3'd4, 32'h0, "pulse_done_status");

        // reset mid-pulse and mid-window
        wr(3'd5, KEY);
        wr(3'd3, 32'h0F);
        idle(3);
        wr(3'd5, KEY);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd0);
        push(1, K_OUT, "midreset_out", 32'hA5);
        push(1, K_IRQ, "midreset_irq", 32'd0);
        push(1, K_RD, "midreset_readdata", 32'd0);
        idle(1);
        rd(3'd4, 32'h0, "midreset_status");
        wr(3'd0, 32'h00);
        push(1, K_IRQ, "midreset_locked_irq", 32'd1);
        push(2, K_OUT, "midreset_locked_out", 32'hA5);
        wr(3'd4, 32'h4);

        // zero-mask PULSE write cancels a running pulse
        wr(3'd5, KEY);
        wr(3'd3, 32'h03);
        wr(3'd5, KEY);
        wr(3'd3, 32'h00);
        push(2, K_OUT, "zero_mask_out", 32'hA5);
        rd(3'd4, 32'h0, "zero_mask_status");

        // reload on the expiry cycle: one continuous 20-cycle inversion
        wr(3'd5, KEY);
        wr(3'd3, 32'h01);
        for (int d = 2; d <= 21; d++) push(d, K_OUT, "reload_active", 32'hA4);
        push(22, K_OUT, "reload_end", 32'hA5);
        idle(8);
        wr(3'd5, KEY);
        wr(3'd3, 32'h01);
        idle(25);

        if (sbq.size() != 0) begin
            errors += sbq.size();
            checks += sbq.size();
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
